seq_detect_fsm: RTL and testbench

SEQ_DETECT_FSM -- requirements
Module: seq_detect_fsm

---
 rtl/seq_pkg.sv | 17 +
 rtl/seq_window.sv | 48 ++++
 rtl/seq_detect_fsm.sv | 112 +++++++++++
 tb/tb_seq_detect_fsm.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// seq_pkg
// Shared definitions for the serial pattern detector: the FSM state
// encodings and the enumerated state type built on them.
// No ports (package).
package seq_pkg;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_FILL   = 2'b01;
  localparam logic [1:0] ST_DETECT = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    FILL   = ST_FILL,
    DETECT = ST_DETECT
  } state_t;

endpackage

// File: rtl/seq_window.sv
// seq_window
// Serial shift window plus fill counter for the pattern detector.
// Ports:
//   clk   - clock, rising edge
//   rst   - synchronous active-high reset, clears window and fill count
//   clr   - synchronous clear, same effect as rst, wins over shift
//   shift - shift din into bit 0 this cycle
//   din   - serial data bit
//   win   - registered window, win[PAT_LEN-1] is the oldest bit
//   full  - lookahead flag: this shift completes (or keeps) a full window,
//           so the shifted window is a candidate for comparison
module seq_window
  import seq_pkg::*;
#(
  parameter int PAT_LEN = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               shift,
  input  logic               din,
  output logic [PAT_LEN-1:0] win,
  output logic               full
);

  localparam int FW = $clog2(PAT_LEN + 1);

  logic [FW-1:0] fill_cnt;

  // The fill count saturates at PAT_LEN so that a window kept in DETECT
  // stays "full" on every later shift.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      win      <= '0;
      fill_cnt <= '0;
    end else if (shift) begin
      win <= {win[PAT_LEN-2:0], din};
      if (fill_cnt != FW'(PAT_LEN)) begin
        fill_cnt <= fill_cnt + FW'(1);
      end
    end
  end

  // Asserted on the shift that brings the count to PAT_LEN and on every
  // shift after that, which is exactly when the new window must be checked.
  assign full = shift && (fill_cnt >= FW'(PAT_LEN - 1));

endmodule

// File: rtl/seq_detect_fsm.sv
// seq_detect_fsm
// Serial pattern detector with loadable pattern, overlapping or
// non-overlapping match modes and a saturating match counter.
// Ports:
//   clk       - clock, rising edge
//   rst       - synchronous active-high reset, highest priority
//   en        - sample strobe, din consumed only when high
//   din       - serial data bit
//   load      - latch pat and restart detection (wins over en)
//   pat       - target pattern, pat[PAT_LEN-1] expected first
//   overlap   - 1: keep detecting after a match, 0: refill after a match
//   match     - registered one-cycle pulse per detected pattern
//   match_cnt - saturating match count since last load or reset
//   state     - registered FSM state (IDLE=00, FILL=01, DETECT=10)
module seq_detect_fsm #(
  parameter int PAT_LEN = 4,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               din,
  input  logic               load,
  input  logic [PAT_LEN-1:0] pat,
  input  logic               overlap,
  output logic               match,
  output logic [CNT_W-1:0]   match_cnt,
  output logic [1:0]         state
);

  import seq_pkg::*;

  state_t             state_q;
  logic               match_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [PAT_LEN-1:0] pat_q;
  logic [PAT_LEN-1:0] win;
  logic               full;
  logic               shift;
  logic               clr;
  logic               hit;
  logic               unused_oldest;

  // A bit is consumed only while a pattern is armed; a load in the same
  // cycle drops the bit.
  assign shift = en && !load && (state_q == FILL || state_q == DETECT);

  // Compare against the window as it will look after this shift, so the
  // registered match pulse lands one cycle after the evaluated en.
  assign hit = ({win[PAT_LEN-2:0], din} == pat_q);

  // The oldest bit falls out of the shifted window and is never compared.
  assign unused_oldest = win[PAT_LEN-1];

  // Window restarts on load, and after a match in non-overlapping mode so
  // the next match needs PAT_LEN fresh bits.
  assign clr = load || (full && hit && !overlap);

  seq_window #(
    .PAT_LEN(PAT_LEN)
  ) u_window (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .shift(shift),
    .din  (din),
    .win  (win),
    .full (full)
  );

  // Main FSM: reset beats load, load beats any sample. full already implies
  // a valid en in FILL/DETECT, so it marks every evaluated bit. The unused
  // encoding falls back to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      match_q <= 1'b0;
      cnt_q   <= '0;
      pat_q   <= '0;
    end else begin
      match_q <= 1'b0;
      if (load) begin
        pat_q   <= pat;
        cnt_q   <= '0;
        state_q <= FILL;
      end else begin
        case (state_q)
          IDLE: state_q <= IDLE;
          FILL, DETECT: begin
            if (full) begin
              if (hit) begin
                match_q <= 1'b1;
                if (cnt_q != '1) begin
                  cnt_q <= cnt_q + CNT_W'(1);
                end
                state_q <= overlap ? DETECT : FILL;
              end else begin
                state_q <= DETECT;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign match     = match_q;
  assign match_cnt = cnt_q;
  assign state     = state_q;

endmodule

// File: tb/tb_seq_detect_fsm.sv
// tb_seq_detect_fsm
// Directed bench for seq_detect_fsm. Two instances share one stimulus
// stream: dutA (PAT_LEN=4, CNT_W=8, pattern 1011) and dutB (PAT_LEN=2,
// CNT_W=2, pattern 11) for counter saturation. Each step pushes the
// expected outputs of the selected instance into a scoreboard queue; the
// entry is popped and compared one time unit after the next rising edge.
module tb_seq_detect_fsm;

  import seq_pkg::*;

  typedef struct {
    logic       sel;
    logic       m;
    logic [7:0] cnt;
    logic [1:0] st;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       en;
  logic       din;
  logic       load;
  logic       overlap;
  logic [3:0] patA;
  logic [1:0] patB;
  logic       matchA;
  logic [7:0] cntA;
  logic [1:0] stateA;
  logic       matchB;
  logic [1:0] cntB;
  logic [1:0] stateB;

  exp_t sbq[$];
  int   checkCount;
  int   passCount;
  int   failCount;
  int   stepNum;

  localparam logic [1:0] I = ST_IDLE;
  localparam logic [1:0] F = ST_FILL;
  localparam logic [1:0] D = ST_DETECT;

  seq_detect_fsm #(.PAT_LEN(4), .CNT_W(8)) dutA (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .din      (din),
    .load     (load),
    .pat      (patA),
    .overlap  (overlap),
    .match    (matchA),
    .match_cnt(cntA),
    .state    (stateA)
  );

  seq_detect_fsm #(.PAT_LEN(2), .CNT_W(2)) dutB (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .din      (din),
    .load     (load),
    .pat      (patB),
    .overlap  (overlap),
    .match    (matchB),
    .match_cnt(cntB),
    .state    (stateB)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] time limit reached");
  end

  task automatic checkVal(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checkCount++;
    assert (obs === expv) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s step %0d: observed %0h expected %0h", tag, stepNum, obs, expv);
    end
  endtask

  task automatic checkOutput();
    exp_t x;
    if (sbq.size() == 0) begin
      checkCount++;
      failCount++;
      $error("[TB] FAIL scoreboard step %0d: observed empty queue expected entry", stepNum);
    end else begin
      x = sbq.pop_front();
      if (x.sel == 1'b0) begin
        checkVal("A.match", {7'd0, matchA}, {7'd0, x.m});
        checkVal("A.match_cnt", cntA, x.cnt);
        checkVal("A.state", {6'd0, stateA}, {6'd0, x.st});
      end else begin
        checkVal("B.match", {7'd0, matchB}, {7'd0, x.m});
        checkVal("B.match_cnt", {6'd0, cntB}, x.cnt);
        checkVal("B.state", {6'd0, stateB}, {6'd0, x.st});
      end
    end
    stepNum++;
  endtask

  // Drive one cycle of inputs, record what the selected instance must show
  // after the coming edge, then check it.
  task automatic applyStimulus(input logic r, input logic l, input logic e,
                               input logic d, input logic o, input logic s,
                               input logic em, input logic [7:0] ec,
                               input logic [1:0] es);
    exp_t x;
    rst     = r;
    load    = l;
    en      = e;
    din     = d;
    overlap = o;
    x.sel   = s;
    x.m     = em;
    x.cnt   = ec;
    x.st    = es;
    sbq.push_back(x);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    failCount  = 0;
    stepNum    = 0;
    rst     = 1'b1;
    en      = 1'b0;
    din     = 1'b0;
    load    = 1'b0;
    overlap = 1'b0;
    patA    = 4'b1011;
    patB    = 2'b11;
    #2;

    // Reset held 10 cycles with en toggling; both instances checked.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 0, i[0], ~i[0], 0, i[0], 0, 8'd0, I);
    end

    // IDLE ignores samples.
    applyStimulus(0, 0, 1, 1, 1, 0, 0, 8'd0, I);

    // Overlapping mode: stream 1,0,1,1,0,1,1.
    applyStimulus(0, 1, 0, 0, 1, 0, 0, 8'd0, F);
    applyStimulus(0, 0, 1, 1, 1, 0, 0, 8'd0, F);
    applyStimulus(0, 0, 1, 0, 1, 0, 0, 8'd0, F);
    applyStimulus(0, 0, 1, 1, 1, 0, 0, 8'd0, F);
    applyStimulus(0, 0, 1, 1, 1, 0, 1, 8'd1, D);
    applyStimulus(0, 0, 1, 0, 1, 0, 0, 8'd1, D);
    applyStimulus(0, 0, 1, 1, 1, 0, 0, 8'd1, D);
    applyStimulus(0, 0, 1, 1, 1, 0, 1, 8'd2, D);
    applyStimulus(0, 0, 0, 1, 1, 0, 0, 8'd2, D);

    // Non-overlapping mode: same stream, single match, ends in FILL.
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 8'd0, F);
    applyStimulus(0, 0, 1, 1, 0, 0, 0, 8'd0, F);
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 8'd0, F);
    applyStimulus(0, 0, 1, 1, 0, 0, 0, 8'd0, F);
    applyStimulus(0, 0, 1, 1, 0, 0, 1, 8'd1, F);
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 8'd1, F);
    applyStimulus(0, 0, 1, 1, 0, 0, 0, 8'd1, F);
    applyStimulus(0, 0, 1, 1, 0, 0, 0, 8'd1, F);

    // Gapped en: idle cycles between bits hold everything.
    applyStimulus(0, 1, 0, 0, 1, 0, 0, 8'd0, F);
    applyStimulus(0, 0, 1, 1, 1, 0, 0, 8'd0, F);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 8'd0, F);
    applyStimulus(0, 0, 1, 0, 1, 0, 0, 8'd0, F);
    applyStimulus(0, 0, 0, 1, 1, 0, 0, 8'd0, F);
    applyStimulus(0, 0, 1, 1, 1, 0, 0, 8'd0, F);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 8'd0, F);
    applyStimulus(0, 0, 1, 1, 1, 0, 1, 8'd1, D);
    applyStimulus(0, 0, 0, 1, 1, 0, 0, 8'd1, D);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 8'd1, D);

    // Window becomes 1101; next 1 would match, but load takes the cycle.
    applyStimulus(0, 0, 1, 0, 1, 0, 0, 8'd1, D);
    applyStimulus(0, 0, 1, 1, 1, 0, 0, 8'd1, D);
    applyStimulus(0, 1, 1, 1, 1, 0, 0, 8'd0, F);
    // Dropped bit means 0,1,1 is only three bits: no match yet.
    applyStimulus(0, 0, 1, 0, 1, 0, 0, 8'd0, F);
    applyStimulus(0, 0, 1, 1, 1, 0, 0, 8'd0, F);
    applyStimulus(0, 0, 1, 1, 1, 0, 0, 8'd0, F);
    applyStimulus(0, 0, 1, 0, 1, 0, 0, 8'd0, D);

    // Reset beats a same-cycle load; afterwards nothing is armed.
    applyStimulus(1, 1, 1, 1, 1, 0, 0, 8'd0, I);
    applyStimulus(0, 0, 1, 1, 1, 0, 0, 8'd0, I);
    applyStimulus(0, 0, 1, 0, 1, 0, 0, 8'd0, I);
    applyStimulus(0, 0, 1, 1, 1, 0, 0, 8'd0, I);
    applyStimulus(0, 0, 1, 1, 1, 0, 0, 8'd0, I);

    // Saturation on the 2-bit counter with pattern 11 and six 1s.
    applyStimulus(0, 1, 0, 0, 1, 1, 0, 8'd0, F);
    applyStimulus(0, 0, 1, 1, 1, 1, 0, 8'd0, F);
    applyStimulus(0, 0, 1, 1, 1, 1, 1, 8'd1, D);
    applyStimulus(0, 0, 1, 1, 1, 1, 1, 8'd2, D);
    applyStimulus(0, 0, 1, 1, 1, 1, 1, 8'd3, D);
    applyStimulus(0, 0, 1, 1, 1, 1, 1, 8'd3, D);
    applyStimulus(0, 0, 1, 1, 1, 1, 1, 8'd3, D);
    applyStimulus(0, 0, 0, 1, 1, 1, 0, 8'd3, D);

    if (failCount != 0) begin
      $display("[TB] %0d checks did not agree", failCount);
    end
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
